// File: rtl/adc_log_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel ADC averaging logger.
package adc_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Channel-index width; a single channel still carries one index bit.
    function automatic int ciw_f(input int n);
        return (clog2_f(n) < 1) ? 1 : clog2_f(n);
    endfunction

endpackage

// File: rtl/adc_avg_logger_if.sv
// ADC response stream plus buffer read port of the averaging logger.
interface adc_avg_logger_if #(
    parameter int ADC_W = 12,
    parameter int RDW   = 13
);
    // Handshake: the ADC stream has no backpressure, a sample is consumed in the cycle
    // adc_valid is high; rd_en is a request taken only when the buffer is not empty and
    // is answered by a one-cycle rd_valid pulse with rd_data on the following cycle.
    logic             adc_valid;
    logic [4:0]       adc_channel;
    logic [ADC_W-1:0] adc_data;
    logic             rd_en;
    logic [RDW-1:0]   rd_data;
    logic             rd_valid;

    modport master (
        output adc_valid, adc_channel, adc_data, rd_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  adc_valid, adc_channel, adc_data, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/sample_ring_buf.sv
// Simple dual-port sample store with a registered read port; old data on same-address read/write.
module sample_ring_buf
    import adc_log_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 13,
    localparam int AW   = clog2_f(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/adc_avg_logger.sv
// Per-channel box-car averager feeding a circular log of {channel, average} entries.
module adc_avg_logger
    import adc_log_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CH_BASE  = 1,
    parameter int ADC_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 16,
    localparam int CIW     = ciw_f(NUM_CH),
    localparam int AW      = clog2_f(DEPTH),
    localparam int CW      = AW + 1,
    localparam int RDW     = CIW + ADC_W
) (
    input  logic              clk,
    input  logic              rst,
    adc_avg_logger_if.slave   bus,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              oneshot,
    input  logic              start,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              busy,
    output logic [7:0]        led_dout,
    output state_t            state_dbg
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int SCW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'((1 << AVG_LOG2) - 1);

    state_t             r_state;
    logic               r_busy;
    logic [ACC_W-1:0]   r_acc  [NUM_CH];
    logic [SCW-1:0]     r_scnt [NUM_CH];
    logic               r_s1_valid;
    logic [CIW-1:0]     r_s1_idx;
    logic [ADC_W-1:0]   r_s1_avg;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_rd_valid;
    logic [7:0]         r_led;

    logic [5:0]         w_ch_ext;
    logic               w_in_range;
    logic [CIW-1:0]     w_idx;
    logic               w_accept;
    logic [ACC_W-1:0]   w_sum;
    logic               w_last;
    logic               w_empty;
    logic               w_full;
    logic               w_rd_acc;
    logic               w_wr;
    logic               w_ovw;
    logic [RDW-1:0]     w_ram_rdata;

    always_comb begin
        w_ch_ext   = {1'b0, bus.adc_channel};
        w_in_range = (w_ch_ext >= 6'(CH_BASE)) && (w_ch_ext < 6'(CH_BASE + NUM_CH));
        w_idx      = CIW'(w_ch_ext - 6'(CH_BASE));
        w_accept   = bus.adc_valid && (r_state == ST_CAPTURE) && w_in_range &&
                     chan_en[w_idx] && !start;
        w_sum      = r_acc[w_idx] + ACC_W'(bus.adc_data);
        w_last     = (r_scnt[w_idx] == SCNT_LAST);
    end

    // A full buffer in one-shot mode drops writes unless a read frees a slot that cycle.
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == CW'(DEPTH));
        w_rd_acc = bus.rd_en && !w_empty && !start;
        w_wr     = r_s1_valid && !start && (!w_full || w_rd_acc || !oneshot);
        w_ovw    = w_wr && w_full && !w_rd_acc;
    end

    // Stage 1: accumulate; on the last sample of a window register the truncated mean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]  <= '0;
                r_scnt[i] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_avg   <= '0;
        end else if (start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]  <= '0;
                r_scnt[i] <= '0;
            end
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= 1'b0;
            if (w_accept) begin
                if (w_last) begin
                    r_acc[w_idx]  <= '0;
                    r_scnt[w_idx] <= '0;
                    r_s1_valid    <= 1'b1;
                    r_s1_idx      <= w_idx;
                    r_s1_avg      <= w_sum[AVG_LOG2 +: ADC_W];
                end else begin
                    r_acc[w_idx]  <= w_sum;
                    r_scnt[w_idx] <= r_scnt[w_idx] + SCW'(1);
                end
            end
        end
    end

    // Stage 2: ring pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_led      <= '0;
        end else if (start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_led    <= r_s1_avg[ADC_W-1 -: 8];
            end
            if (w_rd_acc || w_ovw) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_ovw) r_overflow <= 1'b1;
            case ({w_wr && !w_ovw, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_state <= ST_CAPTURE;
            r_busy  <= 1'b1;
        end else if ((r_state == ST_CAPTURE) && oneshot && w_wr && !w_rd_acc &&
                     (r_count == CW'(DEPTH - 1))) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
        end
    end

    sample_ring_buf #(
        .DEPTH (DEPTH),
        .W     (RDW)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({r_s1_idx, r_s1_avg}),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    assign bus.rd_data  = w_ram_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign overflow     = r_overflow;
    assign busy         = r_busy;
    assign led_dout     = r_led;
    assign state_dbg    = r_state;
endmodule

// File: tb/tb_adc_avg_logger.sv
// Self-checking bench for adc_avg_logger against a queue-based model of the averaged log.
module tb_adc_avg_logger;
    import adc_log_pkg::*;

    localparam int NUM_CH   = 2;
    localparam int CH_BASE  = 1;
    localparam int ADC_W    = 12;
    localparam int AVG_LOG2 = 2;
    localparam int DEPTH    = 16;
    localparam int RDW      = 13;
    localparam int NS       = 1 << AVG_LOG2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] chan_en;
    logic              oneshot;
    logic              start;
    logic [4:0]        count;
    logic              empty, full, overflow, busy;
    logic [7:0]        led_dout;
    state_t            state_dbg;

    adc_avg_logger_if #(.ADC_W(ADC_W), .RDW(RDW)) bus ();

    adc_avg_logger #(
        .NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .ADC_W(ADC_W),
        .AVG_LOG2(AVG_LOG2), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .chan_en(chan_en), .oneshot(oneshot),
        .start(start), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .busy(busy), .led_dout(led_dout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int             m_sum [NUM_CH];
    int             m_cnt [NUM_CH];
    logic [RDW-1:0] exp_q[$];
    bit             m_capture;
    bit             m_overflow;
    logic [7:0]     m_led;

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end
        exp_q.delete();
        m_overflow = 1'b0;
    endfunction

    function automatic void model_push(input int idx, input int avg);
        if (exp_q.size() == DEPTH) begin
            if (oneshot) return;
            void'(exp_q.pop_front());
            m_overflow = 1'b1;
        end
        exp_q.push_back(RDW'((idx << ADC_W) + avg));
        m_led = 8'(avg / 16);
        if (oneshot && exp_q.size() == DEPTH) m_capture = 1'b0;
    endfunction

    function automatic void model_sample(input int ch, input int d);
        int idx;
        idx = ch - CH_BASE;
        if (!m_capture || idx < 0 || idx >= NUM_CH) return;
        if (!chan_en[idx]) return;
        m_sum[idx] += d;
        m_cnt[idx] += 1;
        if (m_cnt[idx] == NS) begin
            model_push(idx, m_sum[idx] / NS);
            m_sum[idx] = 0;
            m_cnt[idx] = 0;
        end
    endfunction

    function automatic logic [16:0] exp_status();
        return {5'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH,
                m_overflow, m_capture, m_led};
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input int ch, input int d);
        @(negedge clk);
        start           = 1'b0;
        bus.rd_en       = 1'b0;
        bus.adc_valid   = 1'b1;
        bus.adc_channel = 5'(ch);
        bus.adc_data    = 12'(d);
        model_sample(ch, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.adc_valid = 1'b0;
            bus.rd_en     = 1'b0;
            start         = 1'b0;
        end
    endtask

    task automatic set_en(input logic [NUM_CH-1:0] e);
        @(negedge clk);
        bus.adc_valid = 1'b0;
        chan_en       = e;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.adc_valid = 1'b0;
        start         = 1'b1;
        m_capture     = 1'b1;
        model_clear();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_read(output logic v, output logic [RDW-1:0] d);
        @(negedge clk);
        bus.adc_valid = 1'b0;
        bus.rd_en     = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        v = bus.rd_valid;
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.adc_valid   = 1'b0;
        bus.adc_channel = '0;
        bus.adc_data    = '0;
        bus.rd_en       = 1'b0;
        start           = 1'b0;
        m_capture       = 1'b0;
        m_led           = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [29:0] act;
        do_reset();
        @(negedge clk);
        act = {count, empty, full, overflow, busy, led_dout, bus.rd_valid, bus.rd_data};
        n_tests++;
        if (act !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 13'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp %h", act,
                     {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 13'd0});
        end
        n_tests++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_basic();
        logic v;
        logic [RDW-1:0] d;
        logic [RDW-1:0] e;
        chan_en = 2'b11;
        oneshot = 1'b0;
        do_start();
        send(1, 100); send(1, 200); send(1, 300); send(1, 400);
        idle(1);
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL basic_latency1 got %0d exp 0", count);
        end
        idle(1);
        n_tests++;
        if (count !== 5'd1) begin
            n_fail++; $display("FAIL basic_latency2 got %0d exp 1", count);
        end
        e = exp_q.pop_front();
        do_read(v, d);
        n_tests++;
        if (v !== 1'b1 || d !== 13'h00FA || e !== 13'h00FA) begin
            n_fail++; $display("FAIL basic_pop got v=%0b d=%h exp 00fa", v, d);
        end
        n_tests++;
        if (led_dout !== 8'h0F || empty !== 1'b1) begin
            n_fail++; $display("FAIL basic_led got %h empty=%0b exp 0f empty=1", led_dout, empty);
        end
    endtask

    task automatic test_interleave();
        int chs[11] = '{2, 1, 3, 2, 0, 1, 2, 2, 1, 3, 1};
        logic v;
        logic [RDW-1:0] d, e;
        logic [16:0] act;
        chan_en = 2'b11;
        do_start();
        foreach (chs[k]) send(chs[k], $urandom_range(0, 4095));
        set_en(2'b01);
        repeat (3) send(2, $urandom_range(0, 4095));
        idle(3);
        n_tests++;
        if (count !== 5'd2) begin
            n_fail++; $display("FAIL interleave_count got %0d exp 2", count);
        end
        act = {count, empty, full, overflow, busy, led_dout};
        n_tests++;
        if (act !== exp_status()) begin
            n_fail++; $display("FAIL interleave_status got %h exp %h", act, exp_status());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_read(v, d);
            n_tests++;
            if (v !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL interleave_pop got v=%0b d=%h exp %h", v, d, e);
            end
        end
        chan_en = 2'b11;
    endtask

    task automatic test_random();
        logic v;
        logic [RDW-1:0] d, e;
        logic [16:0] act;
        int r;
        oneshot = 1'b0;
        chan_en = 2'b11;
        do_start();
        repeat (160) begin
            r = $urandom_range(0, 9);
            if (r == 0) set_en(2'($urandom_range(0, 3)));
            else if (r <= 2) idle(1);
            else send($urandom_range(0, 3), $urandom_range(0, 4095));
        end
        idle(3);
        act = {count, empty, full, overflow, busy, led_dout};
        n_tests++;
        if (act !== exp_status()) begin
            n_fail++; $display("FAIL random_status got %h exp %h", act, exp_status());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_read(v, d);
            n_tests++;
            if (v !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL random_pop got v=%0b d=%h exp %h", v, d, e);
            end
        end
        chan_en = 2'b11;
    endtask

    task automatic test_oneshot();
        logic v;
        logic [RDW-1:0] d, e;
        logic [16:0] act;
        oneshot = 1'b1;
        chan_en = 2'b11;
        do_start();
        repeat (70) send(1, $urandom_range(0, 4095));
        idle(3);
        n_tests++;
        if (count !== 5'd16 || full !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_DONE) begin
            n_fail++;
            $display("FAIL oneshot_full got count=%0d full=%0b busy=%0b st=%0d exp 16 1 0 %0d",
                     count, full, busy, state_dbg, ST_DONE);
        end
        act = {count, empty, full, overflow, busy, led_dout};
        n_tests++;
        if (act !== exp_status()) begin
            n_fail++; $display("FAIL oneshot_status got %h exp %h", act, exp_status());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_read(v, d);
            n_tests++;
            if (v !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL oneshot_pop got v=%0b d=%h exp %h", v, d, e);
            end
        end
        oneshot = 1'b0;
    endtask

    task automatic test_continuous();
        int s[72];
        logic v;
        logic [RDW-1:0] d, e, third;
        oneshot = 1'b0;
        do_start();
        for (int k = 0; k < 72; k++) begin
            s[k] = $urandom_range(0, 4095);
            send(1, s[k]);
        end
        idle(3);
        n_tests++;
        if (count !== 5'd16 || overflow !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_status got count=%0d ovf=%0b full=%0b exp 16 1 1", count, overflow, full);
        end
        third = RDW'((s[8] + s[9] + s[10] + s[11]) / 4);
        e = exp_q.pop_front();
        do_read(v, d);
        n_tests++;
        if (v !== 1'b1 || d !== third || e !== third) begin
            n_fail++; $display("FAIL cont_first_pop got v=%0b d=%h exp %h", v, d, third);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_read(v, d);
            n_tests++;
            if (v !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL cont_pop got v=%0b d=%h exp %h", v, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v;
        logic [RDW-1:0] d, e, last;
        oneshot = 1'b0;
        do_start();
        repeat (67) send(1, $urandom_range(0, 4095));
        idle(3);
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rw_prefill got full=%0b ovf=%0b exp 1 0", full, overflow);
        end
        e = exp_q.pop_front();
        send(1, $urandom_range(0, 4095));
        @(negedge clk);
        bus.adc_valid = 1'b0;
        bus.rd_en     = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        n_tests++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_same_cycle got v=%0b d=%h count=%0d ovf=%0b exp 1 %h 16 0",
                     bus.rd_valid, bus.rd_data, count, overflow, e);
        end
        @(negedge clk);
        n_tests++;
        if (bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL rw_pulse got rd_valid=%0b exp 0", bus.rd_valid);
        end
        last = e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            do_read(v, d);
            last = e;
            n_tests++;
            if (v !== 1'b1 || d !== e) begin
                n_fail++; $display("FAIL rw_pop got v=%0b d=%h exp %h", v, d, e);
            end
        end
        do_read(v, d);
        n_tests++;
        if (v !== 1'b0 || d !== last || empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_read got v=%0b d=%h empty=%0b exp 0 %h 1", v, d, empty, last);
        end
    endtask

    task automatic test_restart();
        logic v;
        logic [RDW-1:0] d, e;
        logic [29:0] act;
        logic [7:0] led_prev;
        oneshot = 1'b0;
        chan_en = 2'b11;
        // Asynchronous reset in the middle of an average.
        do_start();
        send(1, 4000); send(1, 4000);
        @(negedge clk);
        bus.adc_valid = 1'b0;
        rst = 1'b0;
        #1;
        act = {count, empty, full, overflow, busy, led_dout, bus.rd_valid, bus.rd_data};
        n_tests++;
        if (act !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 13'd0}) begin
            n_fail++; $display("FAIL rst_mid_outputs got %h exp %h", act,
                               {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 13'd0});
        end
        m_capture = 1'b0;
        m_led     = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        do_start();
        repeat (4) send(1, $urandom_range(0, 4095));
        idle(3);
        e = exp_q.pop_front();
        do_read(v, d);
        n_tests++;
        if (v !== 1'b1 || d !== e) begin
            n_fail++; $display("FAIL rst_mid_avg got v=%0b d=%h exp %h", v, d, e);
        end
        // Restart in the middle of an average.
        send(2, 4095); send(2, 4095);
        do_start();
        repeat (4) send(2, $urandom_range(0, 4095));
        idle(3);
        e = exp_q.pop_front();
        do_read(v, d);
        n_tests++;
        if (v !== 1'b1 || d !== e || led_dout !== m_led) begin
            n_fail++; $display("FAIL start_mid_avg got v=%0b d=%h led=%h exp %h led=%h",
                               v, d, led_dout, e, m_led);
        end
        // Restart colliding with a pending buffer write: the write is dropped.
        repeat (3) send(1, 4095);
        led_prev = m_led;
        send(1, 4095);
        do_start();
        m_led = led_prev;
        idle(2);
        n_tests++;
        if (count !== 5'd0 || led_dout !== led_prev || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_drops_write got count=%0d led=%h busy=%0b exp 0 %h 1",
                               count, led_dout, busy, led_prev);
        end
    endtask

    initial begin
        chan_en         = '0;
        oneshot         = 1'b0;
        start           = 1'b0;
        bus.adc_valid   = 1'b0;
        bus.adc_channel = '0;
        bus.adc_data    = '0;
        bus.rd_en       = 1'b0;
        m_capture       = 1'b0;
        m_led           = '0;
        model_clear();
        test_reset();
        test_basic();
        test_interleave();
        test_random();
        test_oneshot();
        test_continuous();
        test_back_to_back();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
